wb_stage_ld: RTL and testbench

- Next-generation writeback stage of the 5-stage RISC-V pipeline. It sits after the MEM_WB register and drives the register-file write port.
- Adds a write-source mux (ALU / load / PC+4), load byte/half extraction with sign/zero extension, and a registered output.
- Adds a wait-for-load FSM. When load data arrives late, the stage stalls the pipeline until the data arrives or a timeout fires.

---
 rtl/wb_stage_ld_pkg.sv | 23 ++
 rtl/wb_stage_ld_load_align.sv | 35 +++
 rtl/wb_stage_ld.sv | 143 ++++++++++++++
 tb/tb_wb_stage_ld.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_ld_pkg.sv
// Shared types and constants for the writeback stage and its load-alignment helper.
// Also used by the MEM-stage forwarding path, which reuses load_align.
package wb_stage_ld_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_RSV = 2'd3
    } wb_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_ld_load_align.sv
// Picks the byte/halfword lane out of a word-aligned load and sign- or zero-extends it.
// Purely combinational; the MEM-stage forwarding path instantiates it as well.
module load_align
    import wb_stage_ld_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw_data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] byte_shift;
    logic [XLEN-1:0] half_shift;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    // Halfword lane comes from off[1] alone; misaligned off[0] is ignored.
    assign byte_shift = raw_data >> {off, 3'b000};
    assign half_shift = raw_data >> {off[1], 4'b0000};
    assign ld_byte    = byte_shift[7:0];
    assign ld_half    = half_shift[15:0];

    always_comb begin
        case (funct3)
            F3_LB:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            F3_LH:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = raw_data;
        endcase
    end

endmodule

// File: rtl/wb_stage_ld.sv
// Writeback stage: selects ALU / load / PC+4 result, registers the register-file write,
// and stalls the pipeline while a load response is outstanding (with optional timeout).
module wb_stage_ld
    import wb_stage_ld_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RD_W       = 5,
    parameter int LD_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] MEM_WB_alu_res,
    input  logic [XLEN-1:0] MEM_WB_pc4,
    input  logic [1:0]      MEM_WB_wb_sel,
    input  logic [2:0]      MEM_WB_funct3,
    input  logic            MEM_WB_vld,
    input  logic [RD_W-1:0] MEM_WB_rd,
    input  logic            mem_rsp_vld,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [XLEN-1:0] WB_data,
    output logic [RD_W-1:0] WB_rd,
    output logic            WB_we,
    output logic            WB_stall,
    output logic            WB_err
);

    localparam int CNT_W = (LD_TIMEOUT < 2) ? 1 : $clog2(LD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LD_TIMEOUT == 0) ? 0 : LD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    wb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RD_W-1:0] pend_rd_q, pend_rd_d;
    logic [2:0]      pend_f3_q, pend_f3_d;
    logic [1:0]      pend_off_q, pend_off_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            we_q, we_d;
    logic            err_q, err_d;

    logic [2:0]      la_f3;
    logic [1:0]      la_off;
    logic [XLEN-1:0] la_data;
    wb_sel_e         sel;
    logic            timeout_hit;

    assign sel         = wb_sel_e'(MEM_WB_wb_sel);
    assign timeout_hit = (LD_TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // While waiting, MEM_WB may no longer describe the pending load, so use the captured copy.
    assign la_f3  = (state_q == WAIT) ? pend_f3_q  : MEM_WB_funct3;
    assign la_off = (state_q == WAIT) ? pend_off_q : MEM_WB_alu_res[1:0];

    load_align #(.XLEN(XLEN)) u_load_align (
        .raw_data (mem_rsp_data),
        .funct3   (la_f3),
        .off      (la_off),
        .ld_data  (la_data)
    );

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_rd_d  = pend_rd_q;
        pend_f3_d  = pend_f3_q;
        pend_off_d = pend_off_q;
        data_d     = data_q;
        rd_d       = rd_q;
        we_d       = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (MEM_WB_vld) begin
                    if (sel == WB_MEM && !mem_rsp_vld) begin
                        pend_rd_d  = MEM_WB_rd;
                        pend_f3_d  = MEM_WB_funct3;
                        pend_off_d = MEM_WB_alu_res[1:0];
                        cnt_d      = '0;
                        state_d    = WAIT;
                    end else begin
                        rd_d = MEM_WB_rd;
                        we_d = (MEM_WB_rd != '0) && (sel != WB_RSV);
                        case (sel)
                            WB_MEM:  data_d = la_data;
                            WB_PC4:  data_d = MEM_WB_pc4;
                            default: data_d = MEM_WB_alu_res;
                        endcase
                    end
                end
            end
            WAIT: begin
                // A response in the timeout cycle still completes the load.
                if (mem_rsp_vld) begin
                    data_d  = la_data;
                    rd_d    = pend_rd_q;
                    we_d    = (pend_rd_q != '0);
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: the pending load registers are a handful of flops, so they are reset like the rest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_rd_q  <= '0;
            pend_f3_q  <= '0;
            pend_off_q <= '0;
            data_q     <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_rd_q  <= pend_rd_d;
            pend_f3_q  <= pend_f3_d;
            pend_off_q <= pend_off_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            err_q      <= err_d;
        end
    end

    assign WB_data  = data_q;
    assign WB_rd    = rd_q;
    assign WB_we    = we_q;
    assign WB_stall = (state_q == WAIT);
    assign WB_err   = err_q;

endmodule

// File: tb/tb_wb_stage_ld.sv
// Directed bench for wb_stage_ld with a short load timeout (4 cycles).
module tb_wb_stage_ld;

    logic        clk;
    logic        rst;
    logic [31:0] alu_res;
    logic [31:0] pc4;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic        vld;
    logic [4:0]  rd;
    logic        rsp_vld;
    logic [31:0] rsp_data;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        wb_stall;
    logic        wb_err;

    int n_vec = 0;
    int n_err = 0;

    wb_stage_ld #(.XLEN(32), .RD_W(5), .LD_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_WB_alu_res (alu_res),
        .MEM_WB_pc4     (pc4),
        .MEM_WB_wb_sel  (wb_sel),
        .MEM_WB_funct3  (funct3),
        .MEM_WB_vld     (vld),
        .MEM_WB_rd      (rd),
        .mem_rsp_vld    (rsp_vld),
        .mem_rsp_data   (rsp_data),
        .WB_data        (wb_data),
        .WB_rd          (wb_rd),
        .WB_we          (wb_we),
        .WB_stall       (wb_stall),
        .WB_err         (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] p4, input logic [4:0] r,
                         input logic rv, input logic [31:0] rdat);
        vld = v; wb_sel = s; funct3 = f3; alu_res = alu; pc4 = p4; rd = r;
        rsp_vld = rv; rsp_data = rdat;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 2'd0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        tick();
        tick();
        chk("rst_data",  wb_data, 32'h0);
        chk("rst_rd",    32'(wb_rd), 32'h0);
        chk("rst_we",    32'(wb_we), 32'h0);
        chk("rst_stall", 32'(wb_stall), 32'h0);
        chk("rst_err",   32'(wb_err), 32'h0);
        rst = 1'b1;

        // ALU writes, rd=0 suppresses the enable but still updates data/rd
        drive(1, 2'd0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 0, 32'h0);
        tick();
        chk("alu_we",   32'(wb_we), 32'h1);
        chk("alu_rd",   32'(wb_rd), 32'd5);
        chk("alu_data", wb_data, 32'h1234_5678);
        drive(1, 2'd0, 3'b000, 32'h0BAD_F00D, 32'h0, 5'd0, 0, 32'h0);
        tick();
        chk("alu_rd0_we",   32'(wb_we), 32'h0);
        chk("alu_rd0_data", wb_data, 32'h0BAD_F00D);
        chk("alu_rd0_rd",   32'(wb_rd), 32'd0);

        // Loads with same-cycle response
        drive(1, 2'd1, 3'b000, 32'h0000_1003, 32'h0, 5'd7, 1, 32'h80AA_BBCC);
        tick();
        chk("lb_off3",   wb_data, 32'hFFFF_FF80);
        chk("lb_we",     32'(wb_we), 32'h1);
        chk("lb_stall",  32'(wb_stall), 32'h0);
        drive(1, 2'd1, 3'b100, 32'h0000_1003, 32'h0, 5'd7, 1, 32'h80AA_BBCC);
        tick();
        chk("lbu_off3",  wb_data, 32'h0000_0080);
        drive(1, 2'd1, 3'b001, 32'h0000_1002, 32'h0, 5'd7, 1, 32'h80AA_BBCC);
        tick();
        chk("lh_off2",   wb_data, 32'hFFFF_80AA);
        drive(1, 2'd1, 3'b101, 32'h0000_1000, 32'h0, 5'd7, 1, 32'h80AA_BBCC);
        tick();
        chk("lhu_off0",  wb_data, 32'h0000_BBCC);
        drive(1, 2'd1, 3'b001, 32'h0000_1003, 32'h0, 5'd7, 1, 32'h80AA_BBCC);
        tick();
        chk("lh_off3",   wb_data, 32'hFFFF_80AA);

        // Invalid slot with a spurious response
        drive(0, 2'd1, 3'b010, 32'h0, 32'h0, 5'd7, 1, 32'h5555_5555);
        tick();
        chk("spur_we",    32'(wb_we), 32'h0);
        chk("spur_stall", 32'(wb_stall), 32'h0);
        chk("spur_data",  wb_data, 32'hFFFF_80AA);

        // LW with response three cycles late; MEM_WB changes during WAIT are ignored
        drive(1, 2'd1, 3'b010, 32'h0000_2000, 32'h0, 5'd9, 0, 32'h0);
        tick();
        chk("lw_w1_stall", 32'(wb_stall), 32'h1);
        chk("lw_w1_we",    32'(wb_we), 32'h0);
        drive(1, 2'd0, 3'b000, 32'h0000_5555, 32'h0, 5'd3, 0, 32'h0);
        tick();
        chk("lw_w2_stall", 32'(wb_stall), 32'h1);
        chk("lw_w2_we",    32'(wb_we), 32'h0);
        tick();
        chk("lw_w3_stall", 32'(wb_stall), 32'h1);
        rsp_vld = 1; rsp_data = 32'hDEAD_BEEF;
        tick();
        chk("lw_stall_drop", 32'(wb_stall), 32'h0);
        chk("lw_we",         32'(wb_we), 32'h1);
        chk("lw_data",       wb_data, 32'hDEAD_BEEF);
        chk("lw_rd",         32'(wb_rd), 32'd9);
        drive(0, 2'd0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        tick();
        chk("lw_after_alu_we",   32'(wb_we), 32'h0);

        // Response exactly in the final WAIT cycle wins over the timeout
        drive(1, 2'd1, 3'b001, 32'h0000_3002, 32'h0, 5'd6, 0, 32'h0);
        tick();
        chk("edge_w1_stall", 32'(wb_stall), 32'h1);
        vld = 0;
        tick();
        tick();
        tick();
        chk("edge_w4_stall", 32'(wb_stall), 32'h1);
        rsp_vld = 1; rsp_data = 32'h1234_ABCD;
        tick();
        chk("edge_we",    32'(wb_we), 32'h1);
        chk("edge_data",  wb_data, 32'h0000_1234);
        chk("edge_err",   32'(wb_err), 32'h0);
        chk("edge_stall", 32'(wb_stall), 32'h0);
        rsp_vld = 0;

        // Load with no response: four stalled cycles, then sticky error
        drive(1, 2'd1, 3'b010, 32'h0000_4000, 32'h0, 5'd4, 0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_w%0d_stall", i), 32'(wb_stall), 32'h1);
            chk($sformatf("to_w%0d_we", i),    32'(wb_we), 32'h0);
            vld = 0;
        end
        tick();
        chk("to_err",   32'(wb_err), 32'h1);
        chk("to_we",    32'(wb_we), 32'h0);
        chk("to_stall", 32'(wb_stall), 32'h0);
        tick();
        chk("to_err_sticky", 32'(wb_err), 32'h1);

        // JAL writes PC+4; reserved source never writes
        drive(1, 2'd2, 3'b000, 32'h0000_9999, 32'h0000_0104, 5'd1, 0, 32'h0);
        tick();
        chk("jal_data", wb_data, 32'h0000_0104);
        chk("jal_we",   32'(wb_we), 32'h1);
        chk("jal_rd",   32'(wb_rd), 32'd1);
        drive(1, 2'd3, 3'b000, 32'h0000_9999, 32'h0000_0104, 5'd2, 0, 32'h0);
        tick();
        chk("rsv_we",   32'(wb_we), 32'h0);
        chk("rsv_rd",   32'(wb_rd), 32'd2);

        // Asynchronous reset in the middle of WAIT
        drive(1, 2'd1, 3'b010, 32'h0000_6000, 32'h0, 5'd8, 0, 32'h0);
        tick();
        chk("ar_w1_stall", 32'(wb_stall), 32'h1);
        vld = 0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_data",  wb_data, 32'h0);
        chk("ar_rd",    32'(wb_rd), 32'h0);
        chk("ar_we",    32'(wb_we), 32'h0);
        chk("ar_stall", 32'(wb_stall), 32'h0);
        chk("ar_err",   32'(wb_err), 32'h0);
        #2;
        rst = 1'b1;
        rsp_vld = 1; rsp_data = 32'hFFFF_FFFF;
        tick();
        chk("ar_late_we",    32'(wb_we), 32'h0);
        chk("ar_late_data",  wb_data, 32'h0);
        chk("ar_late_stall", 32'(wb_stall), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
